// File: rtl/serial_echo.sv
// serial_echo: 8E1 UART loopback. Each valid received byte is incremented
// by one, queued in a small FIFO and transmitted back in the same format.
// Optional feature macro: SERIAL_ECHO_FLOW_CTRL_EN (rts/cts hardware
// flow control). Without it rts is ignored and cts is tied low.
module serial_echo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic tx,
    input  logic rts,
    output logic cts,
    output logic tx_led,
    output logic rx_led
);

    localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CNT_W      = $clog2(BIT_TICKS + 1);
    localparam int ADDR_W     = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_TICKS - 1);
    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic             rx_s1, rx_s2, rx_s3;
    logic             rx_fall;
    state_t           rx_state, rx_next;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic             rx_par;
    logic             rx_tick;
    logic             rx_valid;
    logic [7:0]       rx_byte;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall = rx_s3 & ~rx_s2;
    assign rx_tick = (rx_state == S_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

    // Receiver state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= S_IDLE;
        else     rx_state <= rx_next;
    end

    // Receiver next-state logic; a high start-bit sample is treated as a glitch
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:   if (rx_fall) rx_next = S_START;
            S_START:  if (rx_tick) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (rx_tick && rx_idx == 3'd7) rx_next = S_PARITY;
            S_PARITY: if (rx_tick) rx_next = S_STOP;
            S_STOP:   if (rx_tick) rx_next = S_IDLE;
            default:  rx_next = S_IDLE;
        endcase
    end

    // Receiver bit timer, shift register and accept decision at the stop sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (rx_state == S_IDLE || rx_tick) rx_cnt <= '0;
            else                               rx_cnt <= rx_cnt + CNT_W'(1);
            if (rx_state == S_IDLE) rx_idx <= '0;
            if (rx_state == S_DATA && rx_tick) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_idx   <= rx_idx + 3'd1;
            end
            if (rx_state == S_PARITY && rx_tick) rx_par <= rx_s2;
            if (rx_state == S_STOP && rx_tick) begin
                rx_valid <= rx_s2 & ~((^rx_shift) ^ rx_par);
                rx_byte  <= rx_shift + 8'd1;
            end
        end
    end

    // Receiver outputs
    always_comb begin
        rx_led = (rx_state != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Echo FIFO
    // ------------------------------------------------------------------
    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic [7:0]        fifo_head;
    logic              tx_load;

    assign fifo_full  = (count == DEPTH);
    assign fifo_empty = (count == '0);
    assign fifo_wr    = rx_valid & ~fifo_full;
    assign fifo_rd    = tx_load;
    assign fifo_head  = mem[rd_ptr];

    // FIFO storage; contents need no reset since count guards every read
    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= rx_byte;
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep count steady
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({fifo_wr, fifo_rd})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Flow control gate
    // ------------------------------------------------------------------
    logic tx_gate;

`ifdef SERIAL_ECHO_FLOW_CTRL_EN
    assign tx_gate = ~rts;
    assign cts     = ((DEPTH - count) < (ADDR_W + 1)'(2));
`else
    logic unused_rts;
    assign unused_rts = rts;
    assign tx_gate    = 1'b1;
    assign cts        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t           tx_state, tx_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shift;
    logic             tx_par;
    logic             tx_tick;

    assign tx_tick = (tx_cnt == BIT_LAST);
    // A new frame may start from idle or directly at the end of a stop bit
    assign tx_load = tx_gate & ~fifo_empty &
                     ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_tick));

    // Transmitter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= S_IDLE;
        else     tx_state <= tx_next;
    end

    // Transmitter next-state logic; each bit lasts exactly one bit period
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:   if (tx_load) tx_next = S_START;
            S_START:  if (tx_tick) tx_next = S_DATA;
            S_DATA:   if (tx_tick && tx_idx == 3'd7) tx_next = S_PARITY;
            S_PARITY: if (tx_tick) tx_next = S_STOP;
            S_STOP:   if (tx_tick) tx_next = tx_load ? S_START : S_IDLE;
            default:  tx_next = S_IDLE;
        endcase
    end

    // Transmitter bit timer and data shift register, loaded at the FIFO pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else if (tx_load) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= fifo_head;
            tx_par   <= ^fifo_head;
        end else begin
            if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
            else                               tx_cnt <= tx_cnt + CNT_W'(1);
            if (tx_state == S_DATA && tx_tick) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_idx   <= tx_idx + 3'd1;
            end
        end
    end

    // Transmitter line and activity outputs
    always_comb begin
        tx     = 1'b1;
        tx_led = (tx_state != S_IDLE);
        case (tx_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = tx_shift[0];
            S_PARITY: tx = tx_par;
            default:  tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_echo.sv
// tb_serial_echo: scoreboard bench for serial_echo. Runs the design with a
// 16-clock bit period so the full scenario list stays short.
module tb_serial_echo;

    localparam int CLK_FREQ   = 1600000;
    localparam int BAUD_RATE  = 100000;
    localparam int FIFO_DEPTH = 16;
    localparam int BT         = CLK_FREQ / BAUD_RATE;
    localparam int FRAME_CLKS = 11 * BT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic rts = 1'b0;
    logic tx, cts, tx_led, rx_led;

    typedef struct packed {
        logic       start;
        logic [7:0] data;
        logic       par;
        logic       stop;
    } frame_t;

    frame_t     got_q[$];
    logic [7:0] exp_q[$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    time        last_tx_fall  = 0;
    time        last_rx_start = 0;
    int         led_run = 0;
    int         led_len = 0;

    serial_echo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .tx    (tx),
        .rts   (rts),
        .cts   (cts),
        .tx_led(tx_led),
        .rx_led(rx_led)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Decode every frame on tx at mid-bit and queue it for the tests
    initial begin
        frame_t f;
        forever begin
            @(negedge tx);
            last_tx_fall = $time;
            repeat (BT / 2) @(negedge clk);
            f.start = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (BT) @(negedge clk);
                f.data[i] = tx;
            end
            repeat (BT) @(negedge clk);
            f.par = tx;
            repeat (BT) @(negedge clk);
            f.stop = tx;
            got_q.push_back(f);
        end
    end

    // Measure the length of each tx_led pulse in clocks
    always @(negedge clk) begin
        if (tx_led === 1'b1) begin
            led_run = led_run + 1;
        end else if (led_run != 0) begin
            led_len = led_run;
            led_run = 0;
        end
    end

    // Absolute time limit so the run always ends
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        @(negedge clk);
        last_rx_start = $time;
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (BT) @(negedge clk);
        end
    endtask

    task automatic pop_echo(output frame_t f, output bit ok);
        int n;
        n = 0;
        while (got_q.size() == 0 && n < 3 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        ok = (got_q.size() != 0);
        if (ok) f = got_q.pop_front();
        else    f = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        rts = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (tx !== 1'b1)     $display("[TB] FAIL reset_tx: got %b expected 1", tx);         else pass_cnt++;
        total_cnt++; if (tx_led !== 1'b0) $display("[TB] FAIL reset_tx_led: got %b expected 0", tx_led); else pass_cnt++;
        total_cnt++; if (rx_led !== 1'b0) $display("[TB] FAIL reset_rx_led: got %b expected 0", rx_led); else pass_cnt++;
        total_cnt++; if (cts !== 1'b0)    $display("[TB] FAIL reset_cts: got %b expected 0", cts);       else pass_cnt++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total_cnt++; if (tx !== 1'b1)     $display("[TB] FAIL idle_tx: got %b expected 1", tx);          else pass_cnt++;
    endtask

    task automatic test_echo_basic();
        frame_t     f;
        bit         ok;
        logic [7:0] e;
        time        lat;
        exp_q.push_back(8'h54);
        fork
            send_frame(8'h53, 1'b0, 1'b1);
            begin
                repeat (5 * BT) @(negedge clk);
                total_cnt++; if (rx_led !== 1'b1) $display("[TB] FAIL rx_led_busy: got %b expected 1", rx_led); else pass_cnt++;
            end
        join
        pop_echo(f, ok);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok) begin
            $display("[TB] FAIL basic_timeout: got no frame expected %02h", e);
        end else begin
            pass_cnt++;
            lat = last_tx_fall - last_rx_start;
            total_cnt++; if (f.start !== 1'b0) $display("[TB] FAIL basic_start: got %b expected 0", f.start);          else pass_cnt++;
            total_cnt++; if (f.data !== e)     $display("[TB] FAIL basic_data: got %02h expected %02h", f.data, e);    else pass_cnt++;
            total_cnt++; if (f.par !== ^e)     $display("[TB] FAIL basic_parity: got %b expected %b", f.par, ^e);      else pass_cnt++;
            total_cnt++; if (f.stop !== 1'b1)  $display("[TB] FAIL basic_stop: got %b expected 1", f.stop);            else pass_cnt++;
            total_cnt++;
            if (lat < time'(105 * BT) || lat > time'(105 * BT + 50))
                $display("[TB] FAIL echo_latency: got %0t expected %0d..%0d", lat, 105 * BT, 105 * BT + 50);
            else pass_cnt++;
        end
        repeat (2 * BT) @(negedge clk);
        total_cnt++; if (led_len !== FRAME_CLKS) $display("[TB] FAIL tx_led_len: got %0d expected %0d", led_len, FRAME_CLKS); else pass_cnt++;
        total_cnt++; if (rx_led !== 1'b0)        $display("[TB] FAIL rx_led_idle: got %b expected 0", rx_led);                else pass_cnt++;
    endtask

    task automatic test_increment();
        logic [7:0] ins [2];
        frame_t     f;
        bit         ok;
        logic [7:0] e;
        ins[0] = 8'h77;
        ins[1] = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ins[i] + 8'd1);
            send_frame(ins[i], ^ins[i], 1'b1);
            repeat (20 * BT) @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            pop_echo(f, ok);
            e = exp_q.pop_front();
            total_cnt++;
            if (!ok) begin
                $display("[TB] FAIL inc_timeout: got no frame expected %02h", e);
            end else begin
                pass_cnt++;
                total_cnt++; if (f.data !== e) $display("[TB] FAIL inc_data: got %02h expected %02h", f.data, e); else pass_cnt++;
                total_cnt++; if (f.par !== ^e) $display("[TB] FAIL inc_parity: got %b expected %b", f.par, ^e);   else pass_cnt++;
            end
        end
    endtask

    task automatic test_bad_frames();
        frame_t     f;
        bit         ok;
        logic [7:0] e;
        send_frame(8'h53, 1'b1, 1'b1);
        rx = 1'b1;
        repeat (2 * BT) @(negedge clk);
        send_frame(8'h53, 1'b0, 1'b0);
        rx = 1'b1;
        repeat (2 * FRAME_CLKS) @(negedge clk);
        total_cnt++; if (got_q.size() !== 0) $display("[TB] FAIL bad_no_echo: got %0d frames expected 0", got_q.size()); else pass_cnt++;
        total_cnt++; if (tx_led !== 1'b0)    $display("[TB] FAIL bad_tx_led: got %b expected 0", tx_led);                  else pass_cnt++;
        exp_q.push_back(8'h21);
        send_frame(8'h20, ^8'h20, 1'b1);
        pop_echo(f, ok);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok) $display("[TB] FAIL bad_followup_timeout: got no frame expected %02h", e);
        else if (f.data !== e) $display("[TB] FAIL bad_followup_data: got %02h expected %02h", f.data, e);
        else pass_cnt++;
        repeat (2 * BT) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        frame_t     f;
        bit         ok;
        logic [7:0] e;
        int         nsend;
        int         nexp;
`ifdef SERIAL_ECHO_FLOW_CTRL_EN
        nsend = FIFO_DEPTH + 1;
        nexp  = FIFO_DEPTH;
        rts   = 1'b1;
`else
        nsend = 6;
        nexp  = 6;
`endif
        for (int k = 0; k < nsend; k++) begin
            d = 8'($urandom_range(0, 255));
            if (k < nexp) exp_q.push_back(d + 8'd1);
            send_frame(d, ^d, 1'b1);
`ifdef SERIAL_ECHO_FLOW_CTRL_EN
            if (k == FIFO_DEPTH - 3) begin
                total_cnt++; if (cts !== 1'b0) $display("[TB] FAIL cts_at_14: got %b expected 0", cts); else pass_cnt++;
            end
            if (k == FIFO_DEPTH - 2) begin
                total_cnt++; if (cts !== 1'b1) $display("[TB] FAIL cts_at_15: got %b expected 1", cts); else pass_cnt++;
            end
`else
            total_cnt++; if (cts !== 1'b0) $display("[TB] FAIL cts_tied: got %b expected 0", cts); else pass_cnt++;
`endif
        end
        rx = 1'b1;
`ifdef SERIAL_ECHO_FLOW_CTRL_EN
        total_cnt++; if (got_q.size() !== 0) $display("[TB] FAIL held_no_tx: got %0d frames expected 0", got_q.size()); else pass_cnt++;
        total_cnt++; if (tx_led !== 1'b0)    $display("[TB] FAIL held_tx_led: got %b expected 0", tx_led);                 else pass_cnt++;
        rts = 1'b0;
`endif
        for (int k = 0; k < nexp; k++) begin
            pop_echo(f, ok);
            e = exp_q.pop_front();
            total_cnt++;
            if (!ok) begin
                $display("[TB] FAIL b2b_timeout: got no frame %0d expected %02h", k, e);
            end else if (f.data !== e || f.par !== ^e || f.stop !== 1'b1) begin
                $display("[TB] FAIL b2b_frame%0d: got %02h/%b/%b expected %02h/%b/1", k, f.data, f.par, f.stop, e, ^e);
            end else begin
                pass_cnt++;
            end
        end
        repeat (4 * BT) @(negedge clk);
        total_cnt++; if (cts !== 1'b0) $display("[TB] FAIL cts_drained: got %b expected 0", cts); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        frame_t     f;
        bit         ok;
        logic [7:0] e;
        d = 8'h53;
`ifdef SERIAL_ECHO_FLOW_CTRL_EN
        rts = 1'b1;
        send_frame(8'h10, ^8'h10, 1'b1);
`endif
        @(negedge clk);
        rx = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BT) @(negedge clk);
        end
        rx = d[4];
        repeat (BT / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (tx !== 1'b1)     $display("[TB] FAIL midrst_tx: got %b expected 1", tx);         else pass_cnt++;
        total_cnt++; if (tx_led !== 1'b0) $display("[TB] FAIL midrst_tx_led: got %b expected 0", tx_led); else pass_cnt++;
        total_cnt++; if (rx_led !== 1'b0) $display("[TB] FAIL midrst_rx_led: got %b expected 0", rx_led); else pass_cnt++;
        rx  = 1'b1;
        rts = 1'b0;
        rst = 1'b0;
        repeat (2 * FRAME_CLKS) @(negedge clk);
        total_cnt++; if (got_q.size() !== 0) $display("[TB] FAIL midrst_fifo_empty: got %0d frames expected 0", got_q.size()); else pass_cnt++;
        exp_q.push_back(8'h54);
        send_frame(8'h53, 1'b0, 1'b1);
        pop_echo(f, ok);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok) $display("[TB] FAIL midrst_echo_timeout: got no frame expected %02h", e);
        else if (f.data !== e || f.par !== ^e) $display("[TB] FAIL midrst_echo: got %02h/%b expected %02h/%b", f.data, f.par, e, ^e);
        else pass_cnt++;
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_echo_basic();
        test_increment();
        test_bad_frames();
        test_back_to_back();
        test_reset_midframe();
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
